sprite_commit_ctrl: RTL
=======================

# sprite_commit_ctrl

Frame-synchronous commit controller for the sprite object tables of the TinyQV video peripheral. The host writes sprite records into the staging object RAM at any time and requests a commit; this block waits for the next vertical-sync rising edge and copies the staging table byte-by-byte into the active table read by the renderer. Copying only during vertical sync guarantees the renderer never sees a half-updated sprite list. It sits between the host register decode, the `video_controller` sync outputs and the two object RAMs.

## Interface

**Parameters**
- `NUM_BYTES`, default 4: object table size in bytes. Equals sprites × 4 bytes per sprite.
- `ADDR_W`, default 6: table address width.

**Ports**
- `clk` in 1: project clock, 64 MHz nominal.
- `reset` in 1: synchronous, active-high reset.
- `commit_req` in 1: single-cycle pulse from the host control-register write.
- `vsync` in 1: positive-polarity vertical sync from `video_controller`.
- `stage_rd_addr` out ADDR_W: staging RAM read address.
- `stage_rd_data` in 8: staging RAM data. Synchronous read, valid 1 cycle after the address.
- `act_wr_en` out 1: active RAM write strobe.
- `act_wr_addr` out ADDR_W: active RAM write address.
- `act_wr_data` out 8: active RAM write data.
- `host_lock` out 1: high while copying. The host decode must drop staging writes while this is high.
- `commit_pending` out 1: a commit is armed and waiting for vsync.
- `commit_done` out 1: single-cycle pulse when a copy completes.
- `frame_cnt` out 8: count of vsync rising edges. Wraps 255→0.
- `irq` out 1: sticky commit-complete interrupt. See Configuration.
- `irq_clr` in 1: clears `irq`.

## Operation

- **Edge detection.** `vsync_d` is a register copy of `vsync`. `vs_rise = vsync & ~vsync_d`. `frame_cnt` increments on every `vs_rise`, in every state.
- **IDLE.**
  - `commit_req` → ARMED.
  - `vs_rise` alone does nothing.
- **ARMED.**
  - `commit_pending` = 1.
  - `vs_rise` → COPY, with `rd_idx` = 0.
  - Further `commit_req` pulses are absorbed; there is no queueing beyond one.
- **COPY.**
  - Each cycle while `rd_idx` < NUM_BYTES: `stage_rd_addr` = `rd_idx`, then `rd_idx` increments.
  - The write stage is delayed one cycle: `act_wr_en` = 1, `act_wr_addr` = previous `rd_idx`, `act_wr_data` = `stage_rd_data`.
  - After the write of address NUM_BYTES-1 → DONE.
  - A `commit_req` during COPY sets a `re_arm` flag.
- **DONE** (one cycle).
  - `commit_done` = 1.
  - Next state is ARMED if `re_arm` is set (flag cleared), otherwise IDLE.
- `host_lock` = 1 exactly in COPY.
- **Simultaneous events.**
  - `commit_req` and `vs_rise` in the same IDLE cycle → ARMED. The copy waits for the next frame's edge, because a request must precede the edge.
  - `vs_rise` during COPY or DONE only increments `frame_cnt`.
- **Reset mid-copy.**
  - State → IDLE and `act_wr_en` → 0 immediately; `re_arm` and `irq` clear.
  - The active table may be partially updated. This is accepted, and the host must re-commit.
- **Reset values.**
  - Control outputs: `act_wr_en`, `host_lock`, `commit_pending`, `commit_done` and `irq` = 0.
  - Counters and addresses: `frame_cnt`, `stage_rd_addr` and `act_wr_addr` = 0.
  - Data: `act_wr_data` = 0.
- `stage_rd_addr` holds its last value outside COPY. `act_wr_addr` and `act_wr_data` are don't-care when `act_wr_en` = 0.
- **Widths.** `rd_idx` is ADDR_W+1 bits so the terminal compare does not wrap. NUM_BYTES must be ≥ 1 and ≤ 2^ADDR_W.

## Timing

- Let T be the cycle where `vsync` is first sampled high while ARMED. Then:
  - COPY spans T+1 … T+NUM_BYTES+1.
  - Reads are issued T+1 … T+NUM_BYTES.
  - Writes occur T+2 … T+NUM_BYTES+1.
  - `commit_done` is high at T+NUM_BYTES+2.
- `host_lock` is high T+1 … T+NUM_BYTES+1; that is NUM_BYTES+1 cycles.
- `commit_pending` drops at T+1.
- `frame_cnt` updates at T+1.
- The copy fits well inside the vsync pulse (≥ 2 lines) for any NUM_BYTES ≤ 64.

## Configuration

- `SPRITE_COMMIT_IRQ_EN` defined:
  - `irq` sets on `commit_done`.
  - `irq` clears on `irq_clr`. If set and clear coincide, set wins.
- Not defined:
  - `irq` is tied 0 and `irq_clr` is ignored.
  - No sticky flop is instantiated.

## Test plan

- **Basic commit.** Reset; load staging {11,22,33,44}; pulse `commit_req`; raise `vsync`.
  - Writes (0,11),(1,22),(2,33),(3,44) occur on cycles T+2..T+5.
  - `commit_done` is high at T+6 and the state returns to IDLE.
- **No request.** Toggle `vsync` 3 times with no `commit_req`.
  - `act_wr_en` never asserts.
  - `frame_cnt` = 3.
- **Simultaneous request and edge.** `commit_req` and the `vsync` rise in the same cycle.
  - No copy on that edge and `commit_pending` = 1.
  - The copy occurs on the following edge.
- **Re-arm.** `commit_req` during COPY.
  - DONE → ARMED; a second copy on the next edge.
  - Three `commit_req` pulses in ARMED produce one copy only.
- **Reset mid-copy.** Assert `reset` at T+3.
  - Next cycle: `act_wr_en` = 0, `host_lock` = 0, state IDLE.
  - Only addresses 0–1 written.
- **IRQ** (with `SPRITE_COMMIT_IRQ_EN`).
  - `irq` rises the cycle after `commit_done` and holds until `irq_clr`.
  - With `irq_clr` coincident with `commit_done`, `irq` = 1.

Source files
------------

// File: rtl/sprite_commit_ctrl.sv
// Frame-synchronous sprite table commit: copies staging RAM into active RAM on the first vsync rise after a request.
// Optional sticky commit-complete interrupt is built when SPRITE_COMMIT_IRQ_EN is defined; otherwise irq is tied low.
module sprite_commit_ctrl #(
    parameter int NUM_BYTES = 4,
    parameter int ADDR_W    = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              commit_req,
    input  logic              vsync,
    output logic [ADDR_W-1:0] stage_rd_addr,
    input  logic [7:0]        stage_rd_data,
    output logic              act_wr_en,
    output logic [ADDR_W-1:0] act_wr_addr,
    output logic [7:0]        act_wr_data,
    output logic              host_lock,
    output logic              commit_pending,
    output logic              commit_done,
    output logic [7:0]        frame_cnt,
    output logic              irq,
    input  logic              irq_clr
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_COPY,
        S_DONE
    } state_t;

    localparam logic [ADDR_W:0]   NB   = (ADDR_W+1)'(NUM_BYTES);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_BYTES - 1);

    state_t            state_q, state_d;
    logic              vsync_d_q;
    logic [7:0]        frame_cnt_q, frame_cnt_d;
    logic [ADDR_W:0]   rd_idx_q, rd_idx_d;
    logic [ADDR_W-1:0] stage_rd_addr_q, stage_rd_addr_d;
    logic              wr_vld_q, wr_vld_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              re_arm_q, re_arm_d;
    logic              vs_rise;
    logic              issue;

    assign vs_rise = vsync & ~vsync_d_q;
    assign issue   = (state_q == S_COPY) && (rd_idx_q < NB);

    always_comb begin
        state_d         = state_q;
        rd_idx_d        = rd_idx_q;
        stage_rd_addr_d = stage_rd_addr_q;
        wr_vld_d        = 1'b0;
        wr_addr_d       = wr_addr_q;
        re_arm_d        = re_arm_q;
        frame_cnt_d     = frame_cnt_q + (vs_rise ? 8'd1 : 8'd0);

        case (state_q)
            S_IDLE: begin
                // A request coincident with an edge still waits for the next frame.
                if (commit_req) state_d = S_ARMED;
            end
            S_ARMED: begin
                if (vs_rise) begin
                    state_d  = S_COPY;
                    rd_idx_d = '0;
                end
            end
            S_COPY: begin
                if (issue) begin
                    stage_rd_addr_d = rd_idx_q[ADDR_W-1:0];
                    rd_idx_d        = rd_idx_q + 1'b1;
                    wr_vld_d        = 1'b1;
                    wr_addr_d       = rd_idx_q[ADDR_W-1:0];
                end
                if (commit_req) re_arm_d = 1'b1;
                if (wr_vld_q && (wr_addr_q == LAST)) state_d = S_DONE;
            end
            S_DONE: begin
                if (re_arm_q) begin
                    state_d  = S_ARMED;
                    re_arm_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            vsync_d_q       <= 1'b0;
            frame_cnt_q     <= 8'd0;
            rd_idx_q        <= '0;
            stage_rd_addr_q <= '0;
            wr_vld_q        <= 1'b0;
            wr_addr_q       <= '0;
            re_arm_q        <= 1'b0;
        end else begin
            state_q         <= state_d;
            vsync_d_q       <= vsync;
            frame_cnt_q     <= frame_cnt_d;
            rd_idx_q        <= rd_idx_d;
            stage_rd_addr_q <= stage_rd_addr_d;
            wr_vld_q        <= wr_vld_d;
            wr_addr_q       <= wr_addr_d;
            re_arm_q        <= re_arm_d;
        end
    end

    // The read address is driven straight from the index so the RAM sees it in the issue cycle.
    assign stage_rd_addr  = issue ? rd_idx_q[ADDR_W-1:0] : stage_rd_addr_q;
    assign act_wr_en      = wr_vld_q;
    assign act_wr_addr    = wr_addr_q;
    assign act_wr_data    = wr_vld_q ? stage_rd_data : 8'h00;
    assign host_lock      = (state_q == S_COPY);
    assign commit_pending = (state_q == S_ARMED);
    assign commit_done    = (state_q == S_DONE);
    assign frame_cnt      = frame_cnt_q;

`ifdef SPRITE_COMMIT_IRQ_EN
    logic irq_q, irq_d;

    always_comb begin
        irq_d = irq_q;
        if (irq_clr) irq_d = 1'b0;
        if (commit_done) irq_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) irq_q <= 1'b0;
        else       irq_q <= irq_d;
    end

    assign irq = irq_q;
`else
    logic unused_irq_clr;

    assign unused_irq_clr = irq_clr;
    assign irq            = 1'b0;
`endif

endmodule
